// File: rtl/cic_mc_pkg.sv
// Shared types and width helpers for the multi-channel CIC decimator.
package cic_mc_pkg;

   localparam int unsigned CIC_C_DEF  = 4;
   localparam int unsigned CIC_CH_W   = $clog2(CIC_C_DEF);

   // Channel index for the default channel count.
   typedef logic [CIC_CH_W-1:0] cic_ch_t;

   // Internal datapath width: input width plus worst-case CIC bit growth.
   function automatic int unsigned cic_dw(input int unsigned w,
                                          input int unsigned n,
                                          input int unsigned r,
                                          input int unsigned m);
      return w + n * $clog2(r * m);
   endfunction

endpackage

// File: rtl/cic_mc_stage_mem.sv
// Per-channel bank of DEPTH words with a combinational read and a
// same-cycle write-back, so one channel can be updated every cycle.
module cic_mc_stage_mem #(
   parameter int unsigned DW    = 18,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned C     = 4,
   parameter int unsigned CW    = 2
) (
   input  logic                         clk,
   input  logic                         i_clr,
   input  logic                         i_wr_en,
   input  logic [CW-1:0]                i_ch,
   input  logic [DEPTH-1:0][DW-1:0]     i_wr_data,
   output logic [DEPTH-1:0][DW-1:0]     o_rd_data_c
);

   logic [DEPTH-1:0][DW-1:0] r_mem [C];

   assign o_rd_data_c = r_mem[i_ch];

   // Clear has priority over the write so a clear cycle leaves every channel at zero.
   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int unsigned c = 0; c < C; c++) begin
            r_mem[c] <= '0;
         end
      end else if (i_wr_en) begin
         r_mem[i_ch] <= i_wr_data;
      end
   end

endmodule

// File: rtl/cic_decimator_mc.sv
// Time-multiplexed C-channel CIC decimator with runtime ratio and gain.
// Stage 1 integrates and counts, stage 2 runs the combs, stage 3 scales.
module cic_decimator_mc import cic_mc_pkg::*; #(
   parameter int unsigned W    = 10,
   parameter int unsigned N    = 2,
   parameter int unsigned M    = 1,
   parameter int unsigned RMAX = 16,
   parameter int unsigned C    = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cfg_valid,
   input  logic [$clog2(RMAX+1)-1:0]              cfg_ratio,
   input  logic [cic_dw(W, N, RMAX, M)-1:0]       cfg_attn,
   input  logic                                   in_valid,
   input  logic [$clog2(C)-1:0]                   in_ch,
   input  logic [W-1:0]                           in_data,
   output logic                                   out_valid,
   output logic [$clog2(C)-1:0]                   out_ch,
   output logic [W-1:0]                           out_data
);

   localparam int unsigned DW = cic_dw(W, N, RMAX, M);
   localparam int unsigned RW = $clog2(RMAX + 1);
   localparam int unsigned CW = $clog2(C);
   localparam int unsigned NW = (RMAX > 1) ? $clog2(RMAX) : 1;
   localparam int unsigned PW = 2 * DW + 1;

   // Configuration
   logic [RW-1:0]             r_ratio;
   logic [DW-1:0]             r_attn;
   logic [RW-1:0]             w_ratio_cl;
   logic                      w_clr;

   // Stage 1
   logic                      w_ch_ok;
   logic                      w_acc;
   logic [DW-1:0]             w_x;
   logic [N-1:0][DW-1:0]      w_int_rd;
   logic [N-1:0][DW-1:0]      w_int_wr;
   logic [NW-1:0]             r_cnt [C];
   logic [NW-1:0]             w_cnt;
   logic                      w_last;
   logic                      r_ev_valid;
   logic [CW-1:0]             r_ev_ch;
   logic [DW-1:0]             r_ev_data;

   // Stage 2
   logic [N*M-1:0][DW-1:0]    w_dly_rd;
   logic [N*M-1:0][DW-1:0]    w_dly_wr;
   logic [N:0][DW-1:0]        w_y;
   logic                      r_y_valid;
   logic [CW-1:0]             r_y_ch;
   logic [DW-1:0]             r_y_data;

   // Stage 3
   logic signed [PW-1:0]      w_ya;
   logic signed [PW-1:0]      w_aa;
   logic signed [PW-1:0]      w_prod;
   logic                      w_unused_prod;

   assign w_clr = rst | cfg_valid;

   // Clamp the requested ratio into 1..RMAX.
   always_comb begin
      w_ratio_cl = cfg_ratio;
      if (cfg_ratio == '0) begin
         w_ratio_cl = RW'(1);
      end else if (cfg_ratio > RW'(RMAX)) begin
         w_ratio_cl = RW'(RMAX);
      end
   end

   // Ratio and gain registers; reset restores unity ratio and unity gain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ratio <= RW'(1);
         r_attn  <= {1'b1, {(DW-1){1'b0}}};
      end else if (cfg_valid) begin
         r_ratio <= w_ratio_cl;
         r_attn  <= cfg_attn;
      end
   end

   generate
      if (C == (1 << CW)) begin : g_ch_pow2
         assign w_ch_ok = 1'b1;
      end else begin : g_ch_npow2
         assign w_ch_ok = (32'(in_ch) < C);
      end
   endgenerate

   // A sample coinciding with a configuration write is dropped.
   assign w_acc  = in_valid & w_ch_ok & ~cfg_valid;
   assign w_x    = {{(DW-W){in_data[W-1]}}, in_data};
   assign w_cnt  = r_cnt[in_ch];
   assign w_last = (RW'(w_cnt) == (r_ratio - RW'(1)));

   // Integrator chain: each stage adds the previous stage's old value, wrapping mod 2^DW.
   always_comb begin
      w_int_wr    = w_int_rd;
      w_int_wr[0] = w_int_rd[0] + w_x;
      for (int unsigned k = 1; k < N; k++) begin
         w_int_wr[k] = w_int_rd[k] + w_int_rd[k-1];
      end
   end

   cic_mc_stage_mem #(
      .DW    (DW),
      .DEPTH (N),
      .C     (C),
      .CW    (CW)
   ) u_int_mem (
      .clk         (clk),
      .i_clr       (w_clr),
      .i_wr_en     (w_acc),
      .i_ch        (in_ch),
      .i_wr_data   (w_int_wr),
      .o_rd_data_c (w_int_rd)
   );

   // Per-channel decimation counters.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         for (int unsigned c = 0; c < C; c++) begin
            r_cnt[c] <= '0;
         end
      end else if (w_acc) begin
         r_cnt[in_ch] <= w_last ? '0 : (w_cnt + NW'(1));
      end
   end

   // Register a decimation event carrying the newest last-integrator value.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_ev_valid <= 1'b0;
         r_ev_ch    <= '0;
         r_ev_data  <= '0;
      end else begin
         r_ev_valid <= w_acc & w_last;
         if (w_acc) begin
            r_ev_ch   <= in_ch;
            r_ev_data <= w_int_wr[N-1];
         end
      end
   end

   // Comb chain: subtract the M-delayed input of each stage, and shift the delay lines.
   always_comb begin
      w_y      = '0;
      w_dly_wr = w_dly_rd;
      w_y[0]   = r_ev_data;
      for (int unsigned k = 0; k < N; k++) begin
         w_y[k+1]        = w_y[k] - w_dly_rd[k*M + M - 1];
         w_dly_wr[k*M]   = w_y[k];
         for (int unsigned m = 1; m < M; m++) begin
            w_dly_wr[k*M + m] = w_dly_rd[k*M + m - 1];
         end
      end
   end

   cic_mc_stage_mem #(
      .DW    (DW),
      .DEPTH (N*M),
      .C     (C),
      .CW    (CW)
   ) u_dly_mem (
      .clk         (clk),
      .i_clr       (w_clr),
      .i_wr_en     (r_ev_valid),
      .i_ch        (r_ev_ch),
      .i_wr_data   (w_dly_wr),
      .o_rd_data_c (w_dly_rd)
   );

   // Register the comb output and its channel tag.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_y_valid <= 1'b0;
         r_y_ch    <= '0;
         r_y_data  <= '0;
      end else begin
         r_y_valid <= r_ev_valid;
         if (r_ev_valid) begin
            r_y_ch   <= r_ev_ch;
            r_y_data <= w_y[N];
         end
      end
   end

   // Signed comb output times unsigned Q1.(DW-1) gain; bit slice equals a floor shift.
   assign w_ya          = {{(PW-DW){r_y_data[DW-1]}}, r_y_data};
   assign w_aa          = {{(PW-DW){1'b0}}, r_attn};
   assign w_prod        = w_ya * w_aa;
   assign w_unused_prod = ^{w_prod[PW-1:DW-1+W], w_prod[DW-2:0]};

   // Output register: reset clears everything, configuration only kills the strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
      end else if (cfg_valid) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= r_y_valid;
         if (r_y_valid) begin
            out_ch   <= r_y_ch;
            out_data <= w_prod[DW-1 +: W];
         end
      end
   end

endmodule

// File: tb/tb_cic_decimator_mc.sv
// Directed self-checking bench for cic_decimator_mc (W=10, N=2, M=1, RMAX=16, C=4).
module tb_cic_decimator_mc;
   import cic_mc_pkg::*;

   localparam int unsigned W    = 10;
   localparam int unsigned N    = 2;
   localparam int unsigned M    = 1;
   localparam int unsigned RMAX = 16;
   localparam int unsigned C    = 4;
   localparam int unsigned DW   = 18;
   localparam int unsigned RW   = 5;
   localparam int unsigned CW   = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            cfg_valid;
   logic [RW-1:0]   cfg_ratio;
   logic [DW-1:0]   cfg_attn;
   logic            in_valid;
   logic [CW-1:0]   in_ch;
   logic [W-1:0]    in_data;
   logic            out_valid;
   logic [CW-1:0]   out_ch;
   logic [W-1:0]    out_data;

   int n_assert = 0;
   int n_fail   = 0;

   cic_decimator_mc #(
      .W    (W),
      .N    (N),
      .M    (M),
      .RMAX (RMAX),
      .C    (C)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ratio (cfg_ratio),
      .cfg_attn  (cfg_attn),
      .in_valid  (in_valid),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .out_data  (out_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev, input int ech, input int ed);
      chk({tag, ".valid"}, 32'(out_valid), 32'(ev));
      if (ev) begin
         chk({tag, ".ch"}, 32'(out_ch), ech);
         chk({tag, ".data"}, $signed(out_data), ed);
      end
   endtask

   task automatic set_in(input logic v, input cic_ch_t ch, input int d);
      in_valid = v;
      in_ch    = ch;
      in_data  = d[W-1:0];
   endtask

   task automatic cfg(input logic [RW-1:0] r, input logic [DW-1:0] a);
      cfg_valid = 1'b1;
      cfg_ratio = r;
      cfg_attn  = a;
      set_in(1'b0, 2'd0, 0);
      tick();
      cfg_valid = 1'b0;
      chk_out("cfg", 1'b0, 0, 0);
   endtask

   initial begin
      int   j;
      int   nn;
      int   ech;
      int   ed;
      logic ev;

      rst       = 1'b1;
      cfg_valid = 1'b0;
      cfg_ratio = '0;
      cfg_attn  = '0;
      set_in(1'b0, 2'd0, 0);
      tick();
      tick();
      chk("reset.valid", 32'(out_valid), 0);
      chk("reset.ch", 32'(out_ch), 0);
      chk("reset.data", $signed(out_data), 0);
      rst = 1'b0;
      tick();

      // Basic decimation, R=4: 37, 100, 100 three cycles after inputs 4, 8, 12.
      cfg(5'd4, 18'd8192);
      for (int k = 1; k <= 14; k++) begin
         if (k <= 12) set_in(1'b1, 2'd0, 100); else set_in(1'b0, 2'd0, 0);
         tick();
         j  = k - 2;
         ev = (j == 4) || (j == 8) || (j == 12);
         chk_out($sformatf("basic k=%0d", k), ev, 0, (j == 4) ? 37 : 100);
      end

      // Channel interleave: ch0=100, ch1=-50 alternating.
      cfg(5'd4, 18'd8192);
      for (int k = 1; k <= 18; k++) begin
         if (k <= 16) begin
            if ((k % 2) == 1) set_in(1'b1, 2'd0, 100); else set_in(1'b1, 2'd1, -50);
         end else begin
            set_in(1'b0, 2'd0, 0);
         end
         tick();
         j  = k - 2;
         ev = 1'b0;
         ech = 0;
         ed  = 0;
         if (j >= 1 && j <= 16) begin
            ech = (j - 1) % 2;
            nn  = (j + 1) / 2;
            ev  = ((nn % 4) == 0);
            if (nn == 4) ed = (ech == 0) ? 37 : -19;
            else         ed = (ech == 0) ? 100 : -50;
         end
         chk_out($sformatf("ilv k=%0d", k), ev, ech, ed);
      end

      // Unity ratio on ch2: 0 then steady 100, one output per input.
      cfg(5'd1, 18'd131072);
      for (int k = 1; k <= 8; k++) begin
         if (k <= 6) set_in(1'b1, 2'd2, 100); else set_in(1'b0, 2'd0, 0);
         tick();
         j = k - 2;
         chk_out($sformatf("unity k=%0d", k), (j >= 1 && j <= 6), 2, (j == 1) ? 0 : 100);
      end

      // Ratio 0 behaves as ratio 1 (ch3, -50).
      cfg(5'd0, 18'd131072);
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) set_in(1'b1, 2'd3, -50); else set_in(1'b0, 2'd0, 0);
         tick();
         j = k - 2;
         chk_out($sformatf("r0 k=%0d", k), (j >= 1 && j <= 4), 3, (j == 1) ? 0 : -50);
      end

      // Ratio 31 clamps to 16 (ch1, 100): 46 then 100.
      cfg(5'd31, 18'd512);
      for (int k = 1; k <= 34; k++) begin
         if (k <= 32) set_in(1'b1, 2'd1, 100); else set_in(1'b0, 2'd0, 0);
         tick();
         j = k - 2;
         chk_out($sformatf("r31 k=%0d", k), (j == 16) || (j == 32), 1, (j == 16) ? 46 : 100);
      end

      // Reconfigure while a decimation event is in flight: its output is dropped.
      cfg(5'd4, 18'd8192);
      for (int k = 1; k <= 4; k++) begin
         set_in(1'b1, 2'd0, 100);
         tick();
         chk_out($sformatf("flight k=%0d", k), 1'b0, 0, 0);
      end
      cfg(5'd4, 18'd8192);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_out($sformatf("flight idle k=%0d", k), 1'b0, 0, 0);
      end

      // Reconfigure together with a decimating sample: sample dropped, restart from 37.
      for (int k = 1; k <= 3; k++) begin
         set_in(1'b1, 2'd0, 100);
         tick();
         chk_out($sformatf("drop k=%0d", k), 1'b0, 0, 0);
      end
      cfg_valid = 1'b1;
      cfg_ratio = 5'd4;
      cfg_attn  = 18'd8192;
      set_in(1'b1, 2'd0, 100);
      tick();
      cfg_valid = 1'b0;
      chk_out("drop cfg", 1'b0, 0, 0);
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) set_in(1'b1, 2'd0, 100); else set_in(1'b0, 2'd0, 0);
         tick();
         j = k - 2;
         chk_out($sformatf("restart k=%0d", k), (j == 4), 0, 37);
      end

      // Full-scale -512 at R=16: integrators wrap, outputs settle to -512.
      cfg(5'd16, 18'd512);
      for (int k = 1; k <= 2002; k++) begin
         if (k <= 2000) set_in(1'b1, 2'd0, -512); else set_in(1'b0, 2'd0, 0);
         tick();
         j = k - 2;
         chk_out($sformatf("wrap k=%0d", k), (j >= 16) && ((j % 16) == 0), 0,
                 (j == 16) ? -240 : -512);
      end

      // Reset mid-burst on ch3, then a fresh start at default ratio and gain.
      cfg(5'd4, 18'd8192);
      for (int k = 1; k <= 8; k++) begin
         set_in(1'b1, 2'd3, 100);
         tick();
         j = k - 2;
         chk_out($sformatf("prerst k=%0d", k), (j == 4), 3, 37);
      end
      rst = 1'b1;
      set_in(1'b1, 2'd3, 100);
      tick();
      rst = 1'b0;
      chk("rst.valid", 32'(out_valid), 0);
      chk("rst.ch", 32'(out_ch), 0);
      chk("rst.data", $signed(out_data), 0);
      set_in(1'b0, 2'd0, 0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk_out($sformatf("rst idle k=%0d", k), 1'b0, 0, 0);
      end
      for (int k = 1; k <= 5; k++) begin
         if (k <= 3) set_in(1'b1, 2'd3, 100); else set_in(1'b0, 2'd0, 0);
         tick();
         j = k - 2;
         chk_out($sformatf("fresh k=%0d", k), (j >= 1 && j <= 3), 3, (j == 1) ? 0 : 100);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
